// File: rtl/inst_cache_pkg.sv
// Shared types for the instruction cache: the RV32I word type and the
// cache-specific FSM state plus width helpers derived from the geometry.

package rv32i_types;
  typedef logic [31:0] rv32i_word;
endpackage : rv32i_types

package cache_types;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } cache_state_t;

  // Tag width left over once the byte offset and set index are removed.
  function automatic int tag_w(input int s_offset, input int s_index);
    return 32 - s_offset - s_index;
  endfunction

  // Line width in bits for a line of 2**s_offset bytes.
  function automatic int line_w(input int s_offset);
    return 8 * (1 << s_offset);
  endfunction

endpackage : cache_types

// File: rtl/inst_cache_array.sv
// Valid/tag/line storage for the direct-mapped cache. Valid bits are
// cleared by the asynchronous reset. Tags and lines have no reset. There
// is one synchronous write port and one combinational read port.

module cache_array
  import cache_types::*;
#(
  parameter  int S_OFFSET = 5,
  parameter  int S_INDEX  = 3,
  localparam int TAG_W    = tag_w(S_OFFSET, S_INDEX),
  localparam int LINE_W   = line_w(S_OFFSET),
  localparam int SETS     = 1 << S_INDEX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [S_INDEX-1:0] windex,
  input  logic [TAG_W-1:0]   wtag,
  input  logic [LINE_W-1:0]  wline,
  input  logic [S_INDEX-1:0] rindex,
  output logic               rvalid,
  output logic [TAG_W-1:0]   rtag,
  output logic [LINE_W-1:0]  rline
);

  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tags  [SETS];
  logic [LINE_W-1:0] lines [SETS];

  // Valid bits: cleared on reset, set when a fill lands in a set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (we) begin
      valid[windex] <= 1'b1;
    end
  end

  // Tag and line payload: written on a fill, meaningless until valid is set.
  always_ff @(posedge clk) begin
    if (we) begin
      tags[windex]  <= wtag;
      lines[windex] <= wline;
    end
  end

  assign rvalid = valid[rindex];
  assign rtag   = tags[rindex];
  assign rline  = lines[rindex];

endmodule : cache_array

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache. Hits answer in the same cycle.
// A miss latches its line address and fetches the whole line from physical
// memory. The request then hits on the cycle after the fill lands.

module inst_cache
  import rv32i_types::*;
  import cache_types::*;
#(
  parameter  int S_OFFSET = 5,
  parameter  int S_INDEX  = 3,
  localparam int TAG_W    = tag_w(S_OFFSET, S_INDEX),
  localparam int LINE_W   = line_w(S_OFFSET),
  localparam int WSEL_W   = S_OFFSET - 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  rv32i_word         mem_address,
  output rv32i_word         mem_rdata,
  output logic              mem_resp,
  output logic              pmem_read,
  output rv32i_word         pmem_address,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  cache_state_t       state;
  logic [TAG_W-1:0]   fill_tag;
  logic [S_INDEX-1:0] fill_index;

  logic [TAG_W-1:0]   req_tag;
  logic [S_INDEX-1:0] req_index;
  logic [WSEL_W-1:0]  word_sel;
  logic               addr_unused;

  logic               arr_valid;
  logic [TAG_W-1:0]   arr_tag;
  logic [LINE_W-1:0]  arr_line;
  logic               arr_we;
  logic               hit;

  assign req_tag     = mem_address[31 -: TAG_W];
  assign req_index   = mem_address[S_OFFSET +: S_INDEX];
  assign word_sel    = mem_address[2 +: WSEL_W];
  assign addr_unused = ^mem_address[1:0];

  cache_array #(
    .S_OFFSET (S_OFFSET),
    .S_INDEX  (S_INDEX)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .we     (arr_we),
    .windex (fill_index),
    .wtag   (fill_tag),
    .wline  (pmem_rdata),
    .rindex (req_index),
    .rvalid (arr_valid),
    .rtag   (arr_tag),
    .rline  (arr_line)
  );

  // Only lookups made in IDLE can hit, so a request that moves during a
  // fill is never answered until the fill has landed and it is re-checked.
  assign hit       = (state == IDLE) && mem_read && arr_valid && (arr_tag == req_tag);
  assign mem_resp  = hit;
  assign mem_rdata = arr_line[{word_sel, 5'b0} +: 32];

  // The fill writes the latched set only while FILL is live. A reset
  // returns the FSM to IDLE, so a late pmem_resp cannot reach the array.
  assign arr_we = (state == FILL) && pmem_resp;

  // FSM, fill-address register, registered pmem request and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      fill_tag     <= '0;
      fill_index   <= '0;
      pmem_read    <= 1'b0;
      pmem_address <= '0;
      hit_count    <= '0;
      miss_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_read) begin
            if (hit) begin
              hit_count <= hit_count + 32'd1;
            end else begin
              fill_tag     <= req_tag;
              fill_index   <= req_index;
              miss_count   <= miss_count + 32'd1;
              pmem_read    <= 1'b1;
              pmem_address <= {req_tag, req_index, {S_OFFSET{1'b0}}};
              state        <= FILL;
            end
          end
        end
        FILL: begin
          if (pmem_resp) begin
            pmem_read <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          pmem_read <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule : inst_cache
